// File: rtl/dmac_ioregister_initiator.sv
// rtl/dmac_ioregister_initiator.sv - AXI-style burst initiator for DMAC IO-register transfers
// Splits one command into length- and boundary-limited bursts, one transaction in flight at a time.
module dmac_ioregister_initiator #(
  parameter int W_D           = 32,
  parameter int W_EXT_A       = 32,
  parameter int W_BOUNDARY_A  = 12,
  parameter int W_BLEN        = 8,
  parameter int MAX_BURST_LEN = 256,
  parameter int W_SIZE        = 32
) (
  input  logic               ACLK,
  input  logic               ARESET,

  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [W_EXT_A-1:0] req_addr,
  input  logic [W_SIZE-1:0]  req_size,
  output logic               busy,
  output logic               done,

  input  logic [W_D-1:0]     src_data,
  input  logic               src_valid,
  output logic               src_ready,

  output logic [W_D-1:0]     snk_data,
  output logic               snk_valid,
  input  logic               snk_ready,

  output logic               awvalid,
  output logic [W_EXT_A-1:0] awaddr,
  output logic [W_BLEN-1:0]  awlen,
  input  logic               awready,

  output logic               wvalid,
  output logic [W_D-1:0]     wdata,
  output logic [W_D/8-1:0]   wstrb,
  output logic               wlast,
  input  logic               wready,

  output logic               arvalid,
  output logic [W_EXT_A-1:0] araddr,
  output logic [W_BLEN-1:0]  arlen,
  input  logic               arready,

  input  logic               rvalid,
  input  logic [W_D-1:0]     rdata,
  input  logic               rlast,
  output logic               rready
);

  localparam int BYTES      = W_D / 8;
  localparam int BYTE_SHIFT = $clog2(BYTES);
  localparam int W_CALC     = W_SIZE + 1;
  localparam int W_LEN      = W_BLEN + 1;

  typedef logic [W_CALC-1:0]  calc_t;
  typedef logic [W_LEN-1:0]   len_t;
  typedef logic [W_SIZE-1:0]  size_t;
  typedef logic [W_EXT_A-1:0] addr_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_AW,
    S_W,
    S_AR,
    S_R,
    S_DONE
  } state_t;

  state_t state;
  state_t state_next;

  addr_t  addr;
  size_t  remaining;
  logic   dir;
  len_t   len;
  len_t   beat_cnt;

  calc_t  bnd_bytes;
  calc_t  bnd_words;
  calc_t  len_calc;
  len_t   len_m1;
  logic   w_beat;
  logic   r_beat;
  logic   last_beat;
  logic   rem_done;

  // Burst length is the smallest of what is left, the burst cap and the words up to the boundary.
  always_comb begin
    bnd_bytes = (calc_t'(1) << W_BOUNDARY_A) - calc_t'(addr[W_BOUNDARY_A-1:0]);
    bnd_words = bnd_bytes >> BYTE_SHIFT;
    len_calc  = calc_t'(remaining);
    if (calc_t'(MAX_BURST_LEN) < len_calc) len_calc = calc_t'(MAX_BURST_LEN);
    if (bnd_words < len_calc) len_calc = bnd_words;
  end

  assign len_m1    = len - len_t'(1);
  assign w_beat    = (state == S_W) && src_valid && wready;
  assign r_beat    = (state == S_R) && rvalid && snk_ready;
  assign last_beat = (w_beat || r_beat) && (beat_cnt == len_t'(1));
  assign rem_done  = (remaining == size_t'(len));

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (req_valid) state_next = (req_size == '0) ? S_DONE : S_CALC;
      S_CALC: state_next = dir ? S_AW : S_AR;
      S_AW:   if (awready) state_next = S_W;
      S_AR:   if (arready) state_next = S_R;
      S_W,
      S_R:    if (last_beat) state_next = rem_done ? S_DONE : S_CALC;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Address and remaining count advance once per burst, on its final beat.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      addr      <= '0;
      remaining <= '0;
      dir       <= 1'b0;
      len       <= '0;
      beat_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            addr      <= req_addr;
            remaining <= req_size;
            dir       <= req_write;
          end
        end
        S_CALC: begin
          len      <= len_calc[W_LEN-1:0];
          beat_cnt <= len_calc[W_LEN-1:0];
        end
        S_W,
        S_R: begin
          if (w_beat || r_beat) begin
            beat_cnt <= beat_cnt - len_t'(1);
            if (beat_cnt == len_t'(1)) begin
              addr      <= addr + (addr_t'(len) << BYTE_SHIFT);
              remaining <= remaining - size_t'(len);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // req_ready is also masked by reset so every handshake output is low while ARESET is held.
  always_comb begin
    req_ready = (state == S_IDLE) && !ARESET;
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);

    awvalid   = (state == S_AW);
    awaddr    = addr;
    awlen     = len_m1[W_BLEN-1:0];

    arvalid   = (state == S_AR);
    araddr    = addr;
    arlen     = len_m1[W_BLEN-1:0];

    wvalid    = (state == S_W) && src_valid;
    wdata     = src_data;
    wstrb     = '1;
    wlast     = (state == S_W) && (beat_cnt == len_t'(1));
    src_ready = (state == S_W) && wready;

    rready    = (state == S_R) && snk_ready;
    snk_valid = (state == S_R) && rvalid;
    snk_data  = rdata;
  end

  logic unused_bits;
  assign unused_bits = &{1'b0, rlast, len_calc[W_CALC-1:W_LEN], len_m1[W_LEN-1]};

endmodule

// File: tb/tb_dmac_ioregister_initiator.sv
// tb/tb_dmac_ioregister_initiator.sv - directed vector bench for dmac_ioregister_initiator
// A cycle-stepped responder model drives the bus; expected bursts come from the vector table.
module tb_dmac_ioregister_initiator;

  logic        ACLK;
  logic        ARESET;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_size;
  logic        busy, done;
  logic [31:0] src_data;
  logic        src_valid, src_ready;
  logic [31:0] snk_data;
  logic        snk_valid, snk_ready;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic        wvalid, wlast, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic        rvalid, rlast, rready;
  logic [31:0] rdata;

  int n_cmp = 0;
  int n_err = 0;

  dmac_ioregister_initiator dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .busy(busy), .done(done),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready),
    .awvalid(awvalid), .awaddr(awaddr), .awlen(awlen), .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wready(wready),
    .arvalid(arvalid), .araddr(araddr), .arlen(arlen), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rlast(rlast), .rready(rready)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] size;
    int          dly;
    logic [3:0]  pat;
    int          nb;
    logic [31:0] a0;
    logic [7:0]  l0;
    logic [31:0] a1;
    logic [7:0]  l1;
  } vec_t;

  vec_t vecs[8];

  function automatic void chk(int idx, string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL v%0d %s: got %0h, expected %0h", idx, nm, act, exp);
    end
  endfunction

  task automatic idle_inputs();
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_size = '0;
    src_valid = 1'b0; src_data = '0; snk_ready = 1'b0;
    awready = 1'b0; arready = 1'b0; wready = 1'b0;
    rvalid = 1'b0; rdata = '0; rlast = 1'b0;
  endtask

  // Entered and left at posedge+1 with the DUT idle.
  task automatic run_vec(input vec_t v, input int idx);
    logic [31:0] baddr[$];
    logic [7:0]  blen[$];
    logic [31:0] wbase, rbase;
    logic [39:0] hold_key;
    logic        holding, seen_done, finished;
    int          wcnt, rcnt, w_left, r_left, wait_cnt, data_err, last_err, viol;
    wbase = 32'hA000_0000 + (32'(idx) << 16);
    rbase = 32'h5000_0000 + (32'(idx) << 16);
    holding = 1'b0; seen_done = 1'b0; finished = 1'b0;
    wcnt = 0; rcnt = 0; w_left = 0; r_left = 0; wait_cnt = 0;
    data_err = 0; last_err = 0; viol = 0; hold_key = '0;

    idle_inputs();
    req_valid = 1'b1; req_write = v.wr; req_addr = v.addr; req_size = v.size;
    #3;
    chk(idx, "req_ready_idle", req_ready, 1);
    @(posedge ACLK); #1;
    req_valid = 1'b0;

    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (seen_done) begin
        chk(idx, "idle_after_done", {busy, done}, 0);
        finished = 1'b1;
        break;
      end
      awready   = awvalid && (wait_cnt >= v.dly);
      arready   = arvalid && (wait_cnt >= v.dly);
      src_valid = 1'b1;
      src_data  = wbase + 32'(wcnt);
      wready    = v.pat[cyc % 4];
      rvalid    = (r_left > 0);
      rdata     = rbase + 32'(rcnt);
      rlast     = (r_left == 1);
      snk_ready = v.pat[cyc % 4];
      #3;
      if (!busy && !done) viol++;
      if (req_ready) viol++;
      if (awvalid && arvalid) viol++;
      if (v.wr ? arvalid : awvalid) viol++;
      if (w_left == 0 && (src_ready || wvalid)) viol++;
      if (w_left > 0 && !wvalid) viol++;
      if (r_left == 0 && rready) viol++;
      if (r_left > 0 && rready !== snk_ready) viol++;
      if (snk_valid !== (r_left > 0)) viol++;
      if (wvalid && wready) begin
        if (wdata !== wbase + 32'(wcnt) || !src_ready || wstrb !== 4'hF) data_err++;
        if (wlast !== (w_left == 1)) last_err++;
        wcnt++; w_left--;
      end
      if (rvalid && rready) begin
        if (snk_data !== rdata) data_err++;
        rcnt++; r_left--;
      end
      if (awvalid || arvalid) begin
        if (holding && hold_key !== (awvalid ? {awaddr, awlen} : {araddr, arlen})) viol++;
        holding  = 1'b1;
        hold_key = awvalid ? {awaddr, awlen} : {araddr, arlen};
      end
      if (awvalid && awready) begin
        baddr.push_back(awaddr); blen.push_back(awlen);
        w_left = int'(awlen) + 1; holding = 1'b0; wait_cnt = 0;
      end else if (arvalid && arready) begin
        baddr.push_back(araddr); blen.push_back(arlen);
        r_left = int'(arlen) + 1; holding = 1'b0; wait_cnt = 0;
      end else if (awvalid || arvalid) begin
        wait_cnt++;
      end
      if (done) seen_done = 1'b1;
      @(posedge ACLK); #1;
    end
    idle_inputs();

    chk(idx, "completed", finished, 1);
    chk(idx, "burst_count", baddr.size(), v.nb);
    if (v.nb >= 1) begin
      chk(idx, "addr0", baddr.size() >= 1 ? baddr[0] : 32'hDEAD_BEEF, v.a0);
      chk(idx, "len0",  blen.size()  >= 1 ? blen[0]  : 8'hEE, v.l0);
    end
    if (v.nb >= 2) begin
      chk(idx, "addr1", baddr.size() >= 2 ? baddr[1] : 32'hDEAD_BEEF, v.a1);
      chk(idx, "len1",  blen.size()  >= 2 ? blen[1]  : 8'hEE, v.l1);
    end
    chk(idx, "beats", v.wr ? wcnt : rcnt, v.size);
    chk(idx, "data_errors", data_err, 0);
    chk(idx, "wlast_errors", last_err, 0);
    chk(idx, "protocol_violations", viol, 0);
  endtask

  initial begin
    int   beats;
    int   rr_bad;
    vec_t vc;

    vecs[0] = '{1'b1, 32'h0000_0100, 32'd4,   0, 4'b1111, 1, 32'h100,       8'd3,   32'h0,    8'd0};
    vecs[1] = '{1'b1, 32'h0000_0000, 32'd300, 1, 4'b1111, 2, 32'h000,       8'd255, 32'h400,  8'd43};
    vecs[2] = '{1'b0, 32'h0000_0FF8, 32'd8,   0, 4'b1111, 2, 32'hFF8,       8'd1,   32'h1000, 8'd5};
    vecs[3] = '{1'b0, 32'h0000_0040, 32'd6,   3, 4'b1001, 1, 32'h040,       8'd5,   32'h0,    8'd0};
    vecs[4] = '{1'b1, 32'h0000_0300, 32'd0,   0, 4'b1111, 0, 32'h0,         8'd0,   32'h0,    8'd0};
    vecs[5] = '{1'b1, 32'h0000_0FFC, 32'd3,   2, 4'b1101, 2, 32'hFFC,       8'd0,   32'h1000, 8'd1};
    vecs[6] = '{1'b0, 32'h0000_0F00, 32'd100, 0, 4'b0111, 2, 32'hF00,       8'd63,  32'h1000, 8'd35};
    vecs[7] = '{1'b1, 32'hFFFF_FFF8, 32'd4,   1, 4'b1111, 2, 32'hFFFF_FFF8, 8'd1,   32'h0,    8'd1};

    idle_inputs();
    ARESET = 1'b1;
    wready = 1'b1; snk_ready = 1'b1; rvalid = 1'b1; src_valid = 1'b1;
    #12;
    chk(-1, "reset_outputs",
        {req_ready, busy, done, awvalid, arvalid, wvalid, src_ready, rready, snk_valid}, 0);
    chk(-1, "reset_addr", awaddr, 0);
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    idle_inputs();
    @(posedge ACLK); #1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Zero-length command with req_valid held: one DONE cycle, then idle again.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h80; req_size = 32'd0;
    @(posedge ACLK); #1;
    #3;
    chk(8, "zero_done_cycle", {done, busy, req_ready, awvalid, arvalid}, 5'b11000);
    @(posedge ACLK); #1;
    req_valid = 1'b0;
    #3;
    chk(8, "zero_back_idle", {done, busy, req_ready}, 3'b001);
    @(posedge ACLK); #1;

    // Reset in the middle of a write burst, with a second command pending throughout.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h100; req_size = 32'd4;
    src_valid = 1'b1; src_data = 32'h1234_0000; wready = 1'b1; awready = 1'b1;
    @(posedge ACLK); #1;
    req_addr = 32'h500; req_size = 32'd1;
    beats = 0; rr_bad = 0;
    for (int c = 0; c < 50 && beats < 2; c++) begin
      #3;
      if (req_ready) rr_bad++;
      if (wvalid && wready) beats++;
      @(posedge ACLK); #1;
    end
    chk(9, "second_cmd_blocked", rr_bad, 0);
    chk(9, "mid_burst_active", {wvalid, src_ready, busy, beats[3:0]}, 7'b111_0010);
    #1;
    ARESET = 1'b1;
    #1;
    chk(9, "async_reset_clears", {wvalid, src_ready, busy, done, awvalid}, 0);
    req_valid = 1'b0;
    @(posedge ACLK); #1;
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    idle_inputs();
    @(posedge ACLK); #1;
    vc = '{1'b1, 32'h0000_0200, 32'd2, 0, 4'b1111, 1, 32'h200, 8'd1, 32'h0, 8'd0};
    run_vec(vc, 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
